// File: rtl/ptp_sequencer_if.sv
// Core-side request/response and external byte-bus signals of ptp_sequencer.
// slave = sequencer view, master = core/peripheral driver view.
interface ptp_sequencer_if;
  logic        req_i;
  logic        we_i;
  logic [4:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic        err_o;
  logic        busy_o;
  logic [7:0]  ext_data_i;
  logic [7:0]  ext_data_o;
  logic        ext_oe_o;
  logic        ext_strb_o;
  logic        ext_ready_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, ext_data_i, ext_ready_i,
    output rdata_o, ack_o, err_o, busy_o, ext_data_o, ext_oe_o, ext_strb_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, ext_data_i, ext_ready_i,
    input  rdata_o, ack_o, err_o, busy_o, ext_data_o, ext_oe_o, ext_strb_o
  );
endinterface

// File: rtl/ptp_sequencer.sv
// Serialises a 32-bit word access into a command byte plus four data bytes (LSB first).
// Optional stall abort is compiled in with `define PTP_SEQ_TIMEOUT_EN.
module ptp_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  ptp_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CMD, WBYTE, RBYTE, DONE} state_t;

  state_t      state;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [1:0]  beat;
  logic [1:0]  next_beat;
  logic [31:0] rdata;
  logic [7:0]  data_out;
  logic        oe;
  logic        strb;
  logic        ack;
  logic        err;
  logic        beat_done;
  logic        timeout;

  assign beat_done = strb & bus.ext_ready_i;
  assign next_beat = beat + 2'd1;

`ifdef PTP_SEQ_TIMEOUT_EN
  // Counter only needs to reach TIMEOUT_CYCLES-1; the next stalled cycle aborts.
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] stall_cnt;
  logic             stalled;

  assign stalled = strb & ~bus.ext_ready_i;
  assign timeout = stalled && (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stalled && !timeout) begin
      stall_cnt <= stall_cnt + 1'b1;
    end else begin
      stall_cnt <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      we       <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      beat     <= '0;
      rdata    <= '0;
      data_out <= '0;
      oe       <= 1'b0;
      strb     <= 1'b0;
      ack      <= 1'b0;
      err      <= 1'b0;
    end else if (timeout) begin
      state    <= DONE;
      beat     <= '0;
      data_out <= '0;
      oe       <= 1'b0;
      strb     <= 1'b0;
      ack      <= 1'b1;
      err      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_i) begin
            state    <= CMD;
            we       <= bus.we_i;
            addr     <= bus.addr_i;
            wdata    <= bus.wdata_i;
            beat     <= '0;
            data_out <= {bus.we_i, 2'b00, bus.addr_i};
            oe       <= 1'b1;
            strb     <= 1'b1;
          end
        end
        CMD: begin
          if (beat_done) begin
            beat <= '0;
            if (we) begin
              state    <= WBYTE;
              data_out <= wdata[7:0];
            end else begin
              state    <= RBYTE;
              data_out <= '0;
              oe       <= 1'b0;
            end
          end
        end
        WBYTE: begin
          if (beat_done) begin
            beat <= next_beat;
            if (beat == 2'd3) begin
              state    <= DONE;
              data_out <= '0;
              oe       <= 1'b0;
              strb     <= 1'b0;
              ack      <= 1'b1;
            end else begin
              data_out <= wdata[{next_beat, 3'b000} +: 8];
            end
          end
        end
        RBYTE: begin
          if (beat_done) begin
            rdata[{beat, 3'b000} +: 8] <= bus.ext_data_i;
            beat <= next_beat;
            if (beat == 2'd3) begin
              state <= DONE;
              strb  <= 1'b0;
              ack   <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          ack   <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rdata_o    = rdata;
  assign bus.ack_o      = ack;
  assign bus.err_o      = err;
  assign bus.busy_o     = (state != IDLE);
  assign bus.ext_data_o = data_out;
  assign bus.ext_oe_o   = oe;
  assign bus.ext_strb_o = strb;

endmodule

// File: tb/tb_ptp_sequencer.sv
// Directed bench for ptp_sequencer: per-cycle expected trace built from transaction
// descriptions, compared every cycle, plus hand-computed literal pins.
module tb_ptp_sequencer;

  localparam int TO = 4;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        ready;
    logic [7:0]  ext_in;
  } stim_t;

  typedef struct packed {
    logic        busy;
    logic        ack;
    logic        err;
    logic        oe;
    logic        strb;
    logic [7:0]  data;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  ptp_sequencer_if bus();

  ptp_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  stim_t       stimQ[$];
  exp_t        expQ[$];
  logic [31:0] modelRdata;
  int          errors = 0;
  int          checks = 0;
  int          ackCycle;
  logic [31:0] rdataAtAck;
  logic [7:0]  dataSeen[0:63];
  logic        oeSeen[0:63];

  function automatic stim_t mkStim(input logic req, input logic we, input logic [4:0] addr,
                                   input logic [31:0] wdata, input logic ready, input logic [7:0] ext_in);
    stim_t s;
    s.req = req; s.we = we; s.addr = addr; s.wdata = wdata; s.ready = ready; s.ext_in = ext_in;
    return s;
  endfunction

  function automatic exp_t mkExp(input logic busy, input logic ack, input logic err, input logic oe,
                                 input logic strb, input logic [7:0] data, input logic [31:0] rdata);
    exp_t e;
    e.busy = busy; e.ack = ack; e.err = err; e.oe = oe; e.strb = strb; e.data = data; e.rdata = rdata;
    return e;
  endfunction

  function automatic void addIdle(input int n);
    for (int i = 0; i < n; i++) begin
      stimQ.push_back(mkStim(1'b0, 1'b0, 5'h00, 32'h0, 1'b1, 8'h00));
      expQ.push_back(mkExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, modelRdata));
    end
  endfunction

  // One transaction: request cycle, five byte phases (command + 4 data), completion cycle.
  function automatic void buildTxn(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                                   input logic [31:0] rbytes, input int stallPhase, input int stallLen,
                                   input logic holdReq);
    logic [7:0] outByte;
    logic [7:0] inByte;
    int         waits;
    stimQ.push_back(mkStim(1'b1, we, addr, wdata, 1'b1, 8'h00));
    expQ.push_back(mkExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, modelRdata));
    for (int p = 0; p < 5; p++) begin
      waits = (p == stallPhase) ? stallLen : 0;
      if (p == 0) begin
        outByte = {we, 2'b00, addr};
        inByte  = 8'h00;
      end else begin
        inByte  = rbytes[8*(p-1) +: 8];
        outByte = we ? wdata[8*(p-1) +: 8] : 8'h00;
      end
      for (int k = 0; k <= waits; k++) begin
        stimQ.push_back(mkStim(1'b0, we, addr, wdata, (k == waits), inByte));
        expQ.push_back(mkExp(1'b1, 1'b0, 1'b0, (p == 0) || we, 1'b1, outByte, modelRdata));
      end
      if (p > 0 && !we) modelRdata[8*(p-1) +: 8] = inByte;
    end
    stimQ.push_back(mkStim(holdReq, we, addr, wdata, 1'b1, 8'h00));
    expQ.push_back(mkExp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, modelRdata));
  endfunction

  task automatic checkOutput(input exp_t e, input int idx, input string tag);
    exp_t a;
    a = mkExp(bus.busy_o, bus.ack_o, bus.err_o, bus.ext_oe_o, bus.ext_strb_o, bus.ext_data_o, bus.rdata_o);
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: busy/ack/err/oe/strb data rdata got %b%b%b%b%b %h %h expected %b%b%b%b%b %h %h",
               tag, idx, a.busy, a.ack, a.err, a.oe, a.strb, a.data, a.rdata,
               e.busy, e.ack, e.err, e.oe, e.strb, e.data, e.rdata);
    end
    if (idx >= 0 && idx < 64) begin
      dataSeen[idx] = a.data;
      oeSeen[idx]   = a.oe;
      if (a.ack === 1'b1) begin
        ackCycle   = idx;
        rdataAtAck = a.rdata;
      end
    end
  endtask

  task automatic checkLit(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Entered and left at posedge+1; drives each entry, checks at the following negedge.
  task automatic applyStimulus(input string tag, input int n);
    int    lim;
    stim_t s;
    exp_t  e;
    lim = (n < 0 || n > stimQ.size()) ? stimQ.size() : n;
    ackCycle = -1;
    for (int i = 0; i < lim; i++) begin
      s = stimQ.pop_front();
      e = expQ.pop_front();
      bus.req_i       = s.req;
      bus.we_i        = s.we;
      bus.addr_i      = s.addr;
      bus.wdata_i     = s.wdata;
      bus.ext_ready_i = s.ready;
      bus.ext_data_i  = s.ext_in;
      @(negedge clk);
      checkOutput(e, i, tag);
      @(posedge clk);
      #1;
    end
  endtask

  logic [7:0] wrBytes[0:4];

  initial begin
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = 5'h00; bus.wdata_i = 32'h0;
    bus.ext_data_i = 8'h00; bus.ext_ready_i = 1'b0;
    modelRdata = 32'h0;
    ackCycle = -1;
    rdataAtAck = 32'h0;
    rst_n = 1'b0;
    #12;
    checkOutput(mkExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0), -1, "reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Write DEADBEEF to 0x03 with ready tied high.
    buildTxn(1'b1, 5'h03, 32'hDEADBEEF, 32'h0, -1, 0, 1'b0);
    applyStimulus("write", -1);
    wrBytes[0] = 8'h83; wrBytes[1] = 8'hEF; wrBytes[2] = 8'hBE; wrBytes[3] = 8'hAD; wrBytes[4] = 8'hDE;
    checkLit("write ack cycle", 32'(ackCycle), 32'd6);
    for (int i = 0; i < 5; i++) checkLit("write byte", 32'(dataSeen[i+1]), 32'(wrBytes[i]));

    // Read 0x1F, bytes 11,22,33,44.
    buildTxn(1'b0, 5'h1F, 32'h0, 32'h44332211, -1, 0, 1'b0);
    applyStimulus("read", -1);
    checkLit("read cmd byte", 32'(dataSeen[1]), 32'h1F);
    checkLit("read oe in rbyte", 32'(oeSeen[3]), 32'h0);
    checkLit("read rdata", rdataAtAck, 32'h44332211);
    checkLit("read ack cycle", 32'(ackCycle), 32'd6);

    // Write with 3 stalled cycles on data beat 2; rdata must survive the write.
    buildTxn(1'b1, 5'h03, 32'hDEADBEEF, 32'h0, 3, 3, 1'b0);
    applyStimulus("stall", -1);
    checkLit("stall ack cycle", 32'(ackCycle), 32'd9);
    for (int i = 4; i <= 7; i++) checkLit("stall hold byte", 32'(dataSeen[i]), 32'hAD);
    checkLit("write keeps rdata", rdataAtAck, 32'h44332211);

    // Back-to-back: request held through DONE.
    buildTxn(1'b0, 5'h05, 32'h0, 32'hAABBCCDD, -1, 0, 1'b1);
    buildTxn(1'b1, 5'h10, 32'h12345678, 32'h0, -1, 0, 1'b0);
    applyStimulus("b2b", -1);
    checkLit("b2b idle gap", 32'(dataSeen[7]), 32'h00);
    checkLit("b2b second cmd", 32'(dataSeen[8]), 32'h90);
    checkLit("b2b second ack", 32'(ackCycle), 32'd13);
    checkLit("b2b rdata", rdataAtAck, 32'hAABBCCDD);

    // Reset in the middle of a read, right after beat 1 completed.
    buildTxn(1'b0, 5'h0A, 32'h0, 32'h01020304, -1, 0, 1'b0);
    applyStimulus("midread", 4);
    rst_n = 1'b0;
    #1;
    checkOutput(mkExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0), -1, "async reset");
    stimQ.delete();
    expQ.delete();
    modelRdata = 32'h0;
    bus.req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput(mkExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0), -1, "held reset");
    end
    bus.req_i = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    buildTxn(1'b0, 5'h02, 32'h0, 32'hCAFEF00D, -1, 0, 1'b0);
    applyStimulus("post reset read", -1);
    checkLit("post reset rdata", rdataAtAck, 32'hCAFEF00D);
    checkLit("post reset ack cycle", 32'(ackCycle), 32'd6);

    // Read whose data phase never gets ready.
    stimQ.push_back(mkStim(1'b1, 1'b0, 5'h07, 32'h0, 1'b1, 8'h00));
    expQ.push_back(mkExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, modelRdata));
    stimQ.push_back(mkStim(1'b0, 1'b0, 5'h07, 32'h0, 1'b1, 8'h00));
    expQ.push_back(mkExp(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h07, modelRdata));
`ifdef PTP_SEQ_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      stimQ.push_back(mkStim(1'b0, 1'b0, 5'h07, 32'h0, 1'b0, 8'h55));
      expQ.push_back(mkExp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, modelRdata));
    end
    stimQ.push_back(mkStim(1'b0, 1'b0, 5'h07, 32'h0, 1'b0, 8'h55));
    expQ.push_back(mkExp(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, modelRdata));
    addIdle(2);
    applyStimulus("timeout", -1);
    checkLit("timeout ack cycle", 32'(ackCycle), 32'd6);
    checkLit("timeout rdata kept", rdataAtAck, 32'hCAFEF00D);
`else
    for (int i = 0; i < 20; i++) begin
      stimQ.push_back(mkStim(1'b0, 1'b0, 5'h07, 32'h0, 1'b0, 8'h55));
      expQ.push_back(mkExp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, modelRdata));
    end
    applyStimulus("hang", -1);
    checkLit("hang no ack", 32'(ackCycle), 32'hFFFFFFFF);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    modelRdata = 32'h0;
    @(posedge clk);
    #1;
`endif

    // Closing read to confirm the sequencer is usable again.
    buildTxn(1'b0, 5'h11, 32'h0, 32'h89ABCDEF, -1, 0, 1'b0);
    applyStimulus("final read", -1);
    checkLit("final rdata", rdataAtAck, 32'h89ABCDEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ptp_sequencer.md
PTP_SEQUENCER -- requirements
Module: ptp_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, consecutive stalled cycles before abort (used only under PTP_SEQ_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_i  input  1  core memory request, sampled only in IDLE.
REQ-005 SHALL have port we_i  input  1  1=write, 0=read, captured with req_i.
REQ-006 SHALL have port addr_i  input  5  word address (32-word store), captured with req_i.
REQ-007 SHALL have port wdata_i  input  32  write word, captured with req_i.
REQ-008 SHALL have port rdata_o  output  32  assembled read word, valid when ack_o=1.
REQ-009 SHALL have port ack_o  output  1  one-cycle completion pulse.
REQ-010 SHALL have port err_o  output  1  one-cycle abort pulse, coincident with ack_o.
REQ-011 SHALL have port busy_o  output  1  high in every state except IDLE.
REQ-012 SHALL have port ext_data_i  input  8  external read byte.
REQ-013 SHALL have port ext_data_o  output  8  external byte (command or write data).
REQ-014 SHALL have port ext_oe_o  output  1  1 when ext_data_o is driven (CMD, WBYTE).
REQ-015 SHALL have port ext_strb_o  output  1  byte-phase strobe.
REQ-016 SHALL have port ext_ready_i  input  1  external beat acknowledge.

Function
REQ-017 States: IDLE, CMD, WBYTE, RBYTE, DONE; encoding is implementation-defined.
REQ-018 IDLE + req_i=1: capture we_i/addr_i/wdata_i, clear beat counter, go CMD next cycle; req_i=0 stays IDLE.
REQ-019 A beat completes on any rising edge with ext_strb_o=1 and ext_ready_i=1; otherwise the state holds and outputs stay stable.
REQ-020 CMD: ext_data_o = {we, 2'b00, addr[4:0]}, ext_oe_o=1, ext_strb_o=1; on beat go WBYTE if we=1, else RBYTE.
REQ-021 WBYTE: ext_data_o = wdata byte[beat], beat 0 = bits 7:0 (LSB first), ext_oe_o=1, ext_strb_o=1.
REQ-022 RBYTE: ext_oe_o=0, ext_strb_o=1; on beat, ext_data_i stored into rdata byte[beat], LSB first.
REQ-023 Beat counter 2 bits; after beat 3 completes go DONE, counter wraps to 0.
REQ-024 DONE: ack_o=1 for exactly one cycle, then IDLE; req_i is ignored in DONE.
REQ-025 rdata_o holds the last read word until the next read's beat 0 overwrites byte 0; writes leave rdata_o unchanged.
REQ-026 Minimum transaction latency: req_i cycle to ack_o = 6 cycles with ext_ready_i tied high.
REQ-027 ext_data_o = 8'h00 whenever ext_oe_o=0.

Reset
REQ-028 rst_n=0 SHALL asynchronously force IDLE, beat counter 0, rdata_o=0, ack_o=0, err_o=0, busy_o=0, ext_strb_o=0, ext_oe_o=0, ext_data_o=8'h00.
REQ-029 Reset asserted mid-transaction SHALL abort without ack_o; first req_i after release is accepted normally.

Configuration
REQ-030 Macro PTP_SEQ_TIMEOUT_EN defined: stall counter increments each cycle with ext_strb_o=1 and ext_ready_i=0, clears on beat or IDLE; reaching TIMEOUT_CYCLES forces DONE with err_o=1 and ack_o=1, rdata_o bytes not yet received left unchanged.
REQ-031 Macro undefined: no stall counter, err_o tied 0, sequencer waits indefinitely for ext_ready_i.

Verification
REQ-032 Write: req_i, we_i=1, addr_i=5'h03, wdata_i=32'hDEADBEEF, ext_ready_i=1 -> ext_data_o 8'h83, EF, BE, AD, DE on successive cycles, ack_o at cycle 6, err_o=0.
REQ-033 Read: we_i=0, addr_i=5'h1F, ext_data_i 11,22,33,44 per beat -> CMD byte 8'h1F, ext_oe_o=0 in RBYTE, rdata_o=32'h44332211 with ack_o.
REQ-034 Stall: ext_ready_i=0 for 3 cycles during WBYTE beat 2 -> ext_data_o holds 8'hAD, ack_o delayed 3 cycles to cycle 9.
REQ-035 Reset mid-read after beat 1 -> all outputs at reset values immediately, no ack_o; next read completes correctly.
REQ-036 With PTP_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=4, ext_ready_i=0 after CMD -> ack_o=1 and err_o=1 together after 4 stalled cycles, then IDLE; without macro -> busy_o stays 1, no ack_o.
REQ-037 Back-to-back: req_i held high across DONE -> second transaction's CMD begins the cycle after IDLE is re-entered.
